// File: rtl/seq_detector_n_pkg.sv
// Shared defaults and helpers for seq_detector_n and its counter.
`include "seq_defs.vh"

package seq_detector_n_pkg;
  localparam int DEF_WIDTH = `SEQ_DEF_WIDTH;
  localparam int DEF_CNT_W = `SEQ_DEF_CNT_W;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_PAT = `SEQ_DEF_RESET_PAT;

  // Bits needed to hold a fill count that runs from 0 up to and including w.
  function automatic int fill_bits(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count register: clear has priority; increments stop at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_defs.vh
// Default build-time settings for the serial pattern detector.
`ifndef SEQ_DEFS_VH
`define SEQ_DEFS_VH
`define SEQ_DEF_WIDTH     4
`define SEQ_DEF_CNT_W     8
`define SEQ_DEF_RESET_PAT 4'b1101
`endif

// File: rtl/seq_detector_n.sv
// Serial detector for a programmable WIDTH-bit pattern, with optional
// overlapping matches, a registered match pulse and a saturating match count.
//
// Handshake: C is taken on a rising edge only when c_valid=1 and pat_we=0.
// pat_we=1 reloads the pattern and discards any bit offered in that cycle.
module seq_detector_n
  import seq_detector_n_pkg::*;
#(
  parameter int              WIDTH     = DEF_WIDTH,
  parameter int              CNT_W     = DEF_CNT_W,
  parameter logic [WIDTH-1:0] RESET_PAT = DEF_RESET_PAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             C,
  input  logic             c_valid,
  input  logic             overlap,
  input  logic             pat_we,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [WIDTH-1:0] pat
);

  localparam int FW = fill_bits(WIDTH);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);

  logic [WIDTH-1:0] pat_q;
  // Only the WIDTH-1 most recent bits are kept: the incoming bit completes
  // the window, so the oldest bit of a full WIDTH-bit history is never read.
  logic [WIDTH-2:0] hist_q;
  logic [FW-1:0]    fill_q;
  logic             y_q;

  logic             accept;
  logic [WIDTH-1:0] window;
  logic             match;

  // Accept decision, candidate window and match condition for this edge.
  always_comb begin
    accept = c_valid && !pat_we;
    window = {hist_q, C};
    match  = accept && (fill_q >= FILL_LAST) && (window == pat_q);
  end

  // Pattern, history, fill level and match pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else if (pat_we) begin
      pat_q  <= pat_in;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      y_q <= match;
      if (accept) begin
        hist_q <= window[WIDTH-2:0];
        if (match && !overlap) begin
          fill_q <= '0;
        end else if (fill_q < FILL_FULL) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(cnt_clr),
    .q  (match_cnt)
  );

  assign Y   = y_q;
  assign pat = pat_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Bench for seq_detector_n: directed scenarios plus randomized traffic,
// both checked against a bit-queue reference model of the detector rules.
`timescale 1ns/1ps
module tb_seq_detector_n;

  localparam int W = 4;

  logic clk;
  logic rst;
  logic C;
  logic c_valid;
  logic overlap;
  logic pat_we;
  logic [W-1:0] pat_in;
  logic cnt_clr;

  logic         y_a;
  logic [7:0]   cnt_a;
  logic [W-1:0] pat_a;
  logic         y_b;
  logic [1:0]   cnt_b;
  logic [W-1:0] pat_b;

  int checks;
  int failures;

  // Reference model state
  logic [W-1:0] m_pat;
  bit           fresh_q[$];
  int           m_cnt_a;
  int           m_cnt_b;
  logic [0:0]   exp_q[$];

  seq_detector_n dut_a (
    .clk(clk), .rst(rst), .C(C), .c_valid(c_valid), .overlap(overlap),
    .pat_we(pat_we), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .Y(y_a), .match_cnt(cnt_a), .pat(pat_a)
  );

  seq_detector_n #(.WIDTH(4), .CNT_W(2), .RESET_PAT(4'b1101)) dut_b (
    .clk(clk), .rst(rst), .C(C), .c_valid(c_valid), .overlap(overlap),
    .pat_we(pat_we), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .Y(y_b), .match_cnt(cnt_b), .pat(pat_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 4'b1101;
    fresh_q.delete();
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // Rules: a match needs the last W freshly accepted bits (oldest first) to
  // equal the pattern; without overlap a match starts a new fresh run.
  task automatic model_step(input logic c, input logic cv, input logic ov,
                            input logic we, input logic [W-1:0] pin,
                            input logic clr);
    bit hit;
    hit = 0;
    if (we) begin
      m_pat = pin;
      fresh_q.delete();
    end else if (cv) begin
      fresh_q.push_back(c);
      if (fresh_q.size() > W) void'(fresh_q.pop_front());
      if (fresh_q.size() == W) begin
        hit = 1;
        for (int i = 0; i < W; i++)
          if (fresh_q[i] != m_pat[W-1-i]) hit = 0;
        if (hit && !ov) fresh_q.delete();
      end
    end
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    exp_q.push_back(hit);
  endtask

  // One clock: drive, step the model at the edge, check 1 ns later.
  task automatic cycle(input logic c, input logic cv, input logic ov,
                       input logic we, input logic [W-1:0] pin, input logic clr);
    logic [0:0] e;
    C = c; c_valid = cv; overlap = ov; pat_we = we; pat_in = pin; cnt_clr = clr;
    @(posedge clk);
    model_step(c, cv, ov, we, pin, clr);
    #1;
    e = exp_q.pop_front();
    check_eq("y", {31'b0, y_a}, {31'b0, e});
    check_eq("y_sat", {31'b0, y_b}, {31'b0, e});
    check_eq("cnt", {24'b0, cnt_a}, m_cnt_a);
    check_eq("cnt_sat", {30'b0, cnt_b}, m_cnt_b);
    check_eq("pat", {28'b0, pat_a}, {28'b0, m_pat});
    C = 0; c_valid = 0; pat_we = 0; cnt_clr = 0;
  endtask

  task automatic bit_in(input logic c, input logic ov);
    cycle(c, 1'b1, ov, 1'b0, 4'b0, 1'b0);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    check_eq("rst_y", {30'b0, y_a, y_b}, 0);
    check_eq("rst_cnt", {22'b0, cnt_b, cnt_a}, 0);
    check_eq("rst_pat", {24'b0, pat_b, pat_a}, 32'hDD);
    model_reset();
    #2;
    rst = 1;
  endtask

  initial begin
    logic [6:0] s7;
    checks = 0;
    failures = 0;
    C = 0; c_valid = 0; overlap = 1; pat_we = 0; pat_in = 0; cnt_clr = 0;
    rst = 0;
    model_reset();
    #12;
    check_eq("init_y", {31'b0, y_a}, 0);
    check_eq("init_pat", {28'b0, pat_a}, 32'hD);
    rst = 1;

    // Overlapping stream 1101101
    s7 = 7'b1101101;
    for (int i = 6; i >= 0; i--) bit_in(s7[i], 1'b1);
    check_eq("ovl_cnt", {24'b0, cnt_a}, 2);

    // Same stream, no overlap
    do_reset();
    for (int i = 6; i >= 0; i--) bit_in(s7[i], 1'b0);
    check_eq("novl_cnt", {24'b0, cnt_a}, 1);

    // Gap in valid
    do_reset();
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    bit_in(1, 1);
    check_eq("gap_y", {31'b0, y_a}, 1);
    cycle(0, 0, 1, 0, 4'b0, 0);
    check_eq("gap_y_drop", {31'b0, y_a}, 0);

    // Pattern load with a discarded same-cycle bit
    do_reset();
    bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    check_eq("load_pat", {28'b0, pat_a}, 32'h6);
    bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
    check_eq("load_noearly", {31'b0, y_a}, 0);
    bit_in(0, 1);
    check_eq("load_hit", {31'b0, y_a}, 1);

    // Saturation on the 2-bit counter, then clear against a match
    do_reset();
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    for (int k = 0; k < 4; k++) begin
      bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    end
    check_eq("sat_cnt", {30'b0, cnt_b}, 3);
    check_eq("wide_cnt", {24'b0, cnt_a}, 5);
    bit_in(1, 1); bit_in(0, 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b1);
    check_eq("clr_cnt", {30'b0, cnt_b}, 0);
    check_eq("clr_y", {31'b0, y_b}, 1);

    // Reset mid-pattern
    do_reset();
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
    do_reset();
    bit_in(1, 1);
    check_eq("rst_nomatch", {31'b0, y_a}, 0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detector_n.md
SEQ_DETECTOR_N -- requirements
Module: seq_detector_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match-counter width.
REQ-003 The block SHALL have parameter RESET_PAT, default 4'b1101 (WIDTH bits), giving the pattern loaded at reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port C, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port c_valid, input, 1 bit: C is accepted on a rising edge only when c_valid=1.
REQ-008 The block SHALL have port overlap, input, 1 bit: 1 allows overlapping matches, 0 does not.
REQ-009 The block SHALL have port pat_we, input, 1 bit: load-pattern strobe.
REQ-010 The block SHALL have port pat_in, input, WIDTH bits: new pattern, first-received bit in the MSB.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of the match counter.
REQ-012 The block SHALL have port Y, output, 1 bit: registered one-cycle match pulse.
REQ-013 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-014 The block SHALL have port pat, output, WIDTH bits: currently active pattern.

Function
REQ-015 State: pattern register PAT, history shift register H (WIDTH bits), fill counter F (0..WIDTH), counter CNT, output register Y.
REQ-016 On an accepted bit: H <= {H[WIDTH-2:0], C}; F <= min(F+1, WIDTH).
REQ-017 Match condition on an accepted bit: (F+1 >= WIDTH) and {H[WIDTH-2:0], C} == PAT.
REQ-018 On a rising edge, Y SHALL be loaded with the match condition; Y is 1 exactly in the cycle after the edge accepting the completing bit (latency 1), and 0 after any edge with no accepted bit.
REQ-019 overlap=1: on a match, F stays at WIDTH, so the next bit can complete a further match sharing bits with the previous one.
REQ-020 overlap=0: on a match, F SHALL be set to 0, so the next match requires WIDTH fresh bits; H still shifts.
REQ-021 overlap is sampled on the edge of the matching bit; a change of overlap never clears H or F.
REQ-022 pat_we=1: PAT <= pat_in, F <= 0, H <= 0, Y <= 0; any bit offered in the same cycle is discarded (pat_we has priority).
REQ-023 CNT SHALL increment by 1 on each match and saturate at 2^CNT_W-1 (no wrap).
REQ-024 cnt_clr=1 SHALL set CNT to 0, with priority over a same-cycle increment; Y still pulses for that match.
REQ-025 Outputs SHALL be driven as: match_cnt = CNT, pat = PAT, Y = Y register; no combinational path from C to Y.

Reset
REQ-026 rst=0 SHALL asynchronously force PAT=RESET_PAT, H=0, F=0, CNT=0, Y=0, regardless of clk.
REQ-027 Reset asserted mid-pattern SHALL discard the partial history; after release, detection restarts from F=0.
REQ-028 The first rising edge after rst returns to 1 SHALL behave as a normal edge.

Structure
REQ-029 Default WIDTH, CNT_W and RESET_PAT SHALL live in a shared header seq_defs.vh.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter CNT_W; ports clk, rst, inc, clr, q).
REQ-031 The pattern compare, fill counter and history register SHALL be in seq_detector_n itself.

Verification
REQ-032 WIDTH=4, PAT=1101, overlap=1, stream 1,1,0,1,1,0,1 (c_valid=1) -> Y pulses after bits 4 and 7; match_cnt=2.
REQ-033 Same stream with overlap=0 -> Y pulses after bit 4 only; match_cnt=1.
REQ-034 Stream 1,1,0 then c_valid=0 for 3 cycles then bit 1 -> no Y during the gap; Y=1 one cycle after the final accepted bit.
REQ-035 pat_we with pat_in=0110 issued after bits 0,1,1 with C=0 valid in the same cycle -> pat=0110, bit discarded; Y stays 0 until 4 new bits 0,1,1,0 arrive.
REQ-036 CNT_W=2, 5 matches -> match_cnt=3 (saturated); cnt_clr coincident with a 6th match -> match_cnt=0 and Y=1.
REQ-037 rst pulsed low between clock edges after bits 1,1,0 -> Y=0, match_cnt=0, pat=1101 immediately; the following bit 1 does not produce a match.
